// File: rtl/seg_scan_decoder_pkg.sv
// Shared types and segment table for the seven-segment scan decoder.
// Pattern table holds active-low cx[7:1] (a..g) values for hex 0..F.
package seg_scan_decoder_pkg;

    localparam int unsigned SEG_A  = 7;
    localparam int unsigned SEG_B  = 6;
    localparam int unsigned SEG_C  = 5;
    localparam int unsigned SEG_D  = 4;
    localparam int unsigned SEG_E  = 3;
    localparam int unsigned SEG_F  = 2;
    localparam int unsigned SEG_G  = 1;
    localparam int unsigned SEG_DP = 0;

    typedef enum logic [1:0] {
        ClsBlank,
        ClsSlot,
        ClsIllegal
    } slot_class_e;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StHeld
    } state_e;

    function automatic logic [6:0] hex_pattern(input logic [3:0] hex);
        logic [6:0] pat;
        unique case (hex)
            4'h0: pat = 7'h01;
            4'h1: pat = 7'h4F;
            4'h2: pat = 7'h12;
            4'h3: pat = 7'h06;
            4'h4: pat = 7'h4C;
            4'h5: pat = 7'h24;
            4'h6: pat = 7'h20;
            4'h7: pat = 7'h0F;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h04;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h60;
            4'hC: pat = 7'h31;
            4'hD: pat = 7'h42;
            4'hE: pat = 7'h30;
            default: pat = 7'h38;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Scan-line inputs and recovered-frame outputs of the seven-segment decoder.
// master drives the scan lines (display driver or bench); slave is the decoder.
interface seg_scan_decoder_if #(
    parameter int unsigned N_DIGITS = 8
) ();

    logic [N_DIGITS-1:0]   led_en;
    logic [7:0]            led_cx;
    logic [4*N_DIGITS-1:0] digits;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   seg_bad;
    logic                  frame_valid;
    logic                  frame_err;
    logic                  blank;

    modport master (
        output led_en, led_cx,
        input  digits, dp, seg_bad, frame_valid, frame_err, blank
    );

    modport slave (
        input  led_en, led_cx,
        output digits, dp, seg_bad, frame_valid, frame_err, blank
    );

endinterface

// File: rtl/seg_scan_decoder_seg7_to_hex.sv
// Combinational reverse lookup of an active-low a..g pattern to its hex value.
// Unknown patterns report bad with hex forced to zero.
module seg_scan_decoder_seg7_to_hex
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       bad
);

    always_comb begin
        hex = 4'h0;
        bad = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (seg == hex_pattern(4'(i))) begin
                hex = 4'(i);
                bad = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers per-digit hex values and decimal points from multiplexed led_en/led_cx scan lines
// and publishes a full frame once every slot has been captured after a stable dwell.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int unsigned N_DIGITS       = 8,
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input logic clk,
    input logic rst_n,
    seg_scan_decoder_if.slave bus
);

    localparam int unsigned SLOT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned LOW_W  = $clog2(N_DIGITS + 1);
    localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned BLK_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic [N_DIGITS-1:0]       en_q;
    logic [7:0]                cx_q;
    state_e                    state_q;
    logic [SLOT_W-1:0]         slot_q;
    logic [7:0]                cx_ref_q;
    logic [CNT_W-1:0]          stable_cnt_q;
    logic [BLK_W-1:0]          blank_cnt_q;
    logic [N_DIGITS-1:0]       mask_q;
    logic [N_DIGITS-1:0][3:0]  pend_hex_q;
    logic [N_DIGITS-1:0]       pend_dp_q;
    logic [N_DIGITS-1:0]       pend_bad_q;
    logic [N_DIGITS-1:0][3:0]  digits_q;
    logic [N_DIGITS-1:0]       dp_q;
    logic [N_DIGITS-1:0]       seg_bad_q;
    logic                      frame_valid_q;
    logic                      frame_err_q;
    logic                      blank_q;

    logic [LOW_W-1:0]          low_cnt;
    logic [SLOT_W-1:0]         slot_idx;
    slot_class_e               cls;
    logic [3:0]                dec_hex;
    logic                      dec_bad;
    logic                      same;
    logic                      capture;
    logic [N_DIGITS-1:0]       slot_oh;
    logic                      mask_full;
    logic [N_DIGITS-1:0][3:0]  pend_hex_nxt;
    logic [N_DIGITS-1:0]       pend_dp_nxt;
    logic [N_DIGITS-1:0]       pend_bad_nxt;

    // Stage 0: every decision below works on these registered copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= '1;
            cx_q <= '1;
        end else begin
            en_q <= bus.led_en;
            cx_q <= bus.led_cx;
        end
    end

    always_comb begin
        low_cnt  = '0;
        slot_idx = '0;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (!en_q[i]) begin
                low_cnt  = low_cnt + LOW_W'(1);
                slot_idx = SLOT_W'(i);
            end
        end
        if (low_cnt == '0) begin
            cls = ClsBlank;
        end else if (low_cnt == LOW_W'(1)) begin
            cls = ClsSlot;
        end else begin
            cls = ClsIllegal;
        end
    end

    seg_scan_decoder_seg7_to_hex u_seg7_to_hex (
        .seg (cx_q[7:1]),
        .hex (dec_hex),
        .bad (dec_bad)
    );

    always_comb begin
        same         = (slot_idx == slot_q) && (cx_q == cx_ref_q);
        capture      = (cls == ClsSlot) && (state_q == StSettle) && same &&
                       (stable_cnt_q == CNT_W'(STABLE_CYCLES - 1));
        slot_oh      = N_DIGITS'(1) << slot_idx;
        mask_full    = &(mask_q | slot_oh);
        pend_hex_nxt = pend_hex_q;
        pend_dp_nxt  = pend_dp_q;
        pend_bad_nxt = pend_bad_q;
        pend_hex_nxt[slot_idx] = dec_hex;
        pend_dp_nxt[slot_idx]  = ~cx_q[SEG_DP];
        pend_bad_nxt[slot_idx] = dec_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            slot_q        <= '0;
            cx_ref_q      <= '1;
            stable_cnt_q  <= '0;
            blank_cnt_q   <= '0;
            mask_q        <= '0;
            pend_hex_q    <= '0;
            pend_dp_q     <= '0;
            pend_bad_q    <= '0;
            digits_q      <= '0;
            dp_q          <= '0;
            seg_bad_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            blank_q       <= 1'b1;
        end else begin
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            unique case (cls)
                ClsIllegal: begin
                    frame_err_q  <= 1'b1;
                    mask_q       <= '0;
                    state_q      <= StIdle;
                    stable_cnt_q <= '0;
                    blank_cnt_q  <= '0;
                end
                ClsBlank: begin
                    state_q      <= StIdle;
                    stable_cnt_q <= '0;
                    if (blank_cnt_q >= BLK_W'(TIMEOUT_CYCLES - 1)) begin
                        blank_q <= 1'b1;
                        mask_q  <= '0;
                    end else begin
                        blank_cnt_q <= blank_cnt_q + BLK_W'(1);
                    end
                end
                ClsSlot: begin
                    blank_cnt_q <= '0;
                    blank_q     <= 1'b0;
                    if (state_q == StIdle || !same) begin
                        state_q      <= StSettle;
                        stable_cnt_q <= CNT_W'(1);
                        slot_q       <= slot_idx;
                        cx_ref_q     <= cx_q;
                    end else if (capture) begin
                        state_q    <= StHeld;
                        pend_hex_q <= pend_hex_nxt;
                        pend_dp_q  <= pend_dp_nxt;
                        pend_bad_q <= pend_bad_nxt;
                        if (mask_full) begin
                            digits_q      <= pend_hex_nxt;
                            dp_q          <= pend_dp_nxt;
                            seg_bad_q     <= pend_bad_nxt;
                            frame_valid_q <= 1'b1;
                            mask_q        <= '0;
                        end else begin
                            mask_q <= mask_q | slot_oh;
                        end
                    end else if (state_q == StSettle) begin
                        stable_cnt_q <= stable_cnt_q + CNT_W'(1);
                    end
                    // StHeld with an unchanged slot: one capture per dwell.
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.digits      = digits_q;
    assign bus.dp          = dp_q;
    assign bus.seg_bad     = seg_bad_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.blank       = blank_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: table of full-scan vectors plus
// directed sequences for illegal enables, blank timeout and mid-dwell reset.
module tb_seg_scan_decoder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   fv_cnt;
    int   fe_cnt;

    seg_scan_decoder_if #(.N_DIGITS(8)) bus ();

    seg_scan_decoder #(
        .N_DIGITS       (8),
        .STABLE_CYCLES  (16),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.frame_valid) fv_cnt++;
            if (bus.frame_err) fe_cnt++;
        end
    end

    typedef struct {
        logic [63:0] cx_all;
        int          dwell;
        int          exp_frames;
        logic [31:0] exp_digits;
        logic [7:0]  exp_dp;
        logic [7:0]  exp_bad;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] en, input logic [7:0] cx, input int n);
        bus.led_en = en;
        bus.led_cx = cx;
        cycles(n);
    endtask

    task automatic scan(input logic [63:0] cx_all, input int dwell, input int first,
                        input int last);
        logic [7:0] one;
        one = 8'h01;
        for (int s = first; s <= last; s++) begin
            drive(~(one << s), cx_all[8*s +: 8], dwell);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digits"}, bus.digits, 32'h0);
        check({tag, "_dp"}, {24'h0, bus.dp}, 32'h0);
        check({tag, "_seg_bad"}, {24'h0, bus.seg_bad}, 32'h0);
        check({tag, "_frame_valid"}, {31'h0, bus.frame_valid}, 32'h0);
        check({tag, "_frame_err"}, {31'h0, bus.frame_err}, 32'h0);
        check({tag, "_blank"}, {31'h0, bus.blank}, 32'h1);
    endtask

    initial begin
        int fv0;
        int fe0;
        checks = 0;
        errors = 0;
        fv_cnt = 0;
        fe_cnt = 0;

        vecs[0] = '{64'h0303030303030303, 100, 1, 32'h00000000, 8'h00, 8'h00};
        vecs[1] = '{64'h1F4149990D259F00, 100, 1, 32'h76543218, 8'h01, 8'h00};
        vecs[2] = '{64'h0303030303030303, 10,  0, 32'h76543218, 8'h01, 8'h00};
        vecs[3] = '{64'h03030303FE030303, 50,  1, 32'h00000000, 8'h08, 8'h08};
        vecs[4] = '{64'h0171608563C11109, 40,  1, 32'h8FEDCBA9, 8'h20, 8'h00};

        bus.led_en = 8'hFF;
        bus.led_cx = 8'hFF;
        rst_n = 1'b0;
        cycles(3);
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        cycles(2);
        check_reset_outputs("rst_release");

        for (int v = 0; v < 5; v++) begin
            fv0 = fv_cnt;
            scan(vecs[v].cx_all, vecs[v].dwell, 0, 7);
            drive(8'hFF, 8'hFF, 5);
            check($sformatf("vec%0d_frames", v), 32'(fv_cnt - fv0), 32'(vecs[v].exp_frames));
            check($sformatf("vec%0d_digits", v), bus.digits, vecs[v].exp_digits);
            check($sformatf("vec%0d_dp", v), {24'h0, bus.dp}, {24'h0, vecs[v].exp_dp});
            check($sformatf("vec%0d_seg_bad", v), {24'h0, bus.seg_bad}, {24'h0, vecs[v].exp_bad});
        end
        check("no_err_in_vectors", 32'(fe_cnt), 32'h0);

        // Illegal enables drop the partial frame; pending values survive.
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        scan(64'h9F9F9F9F9F9F9F9F, 50, 0, 3);
        drive(8'hFC, 8'h03, 1);
        scan(64'h2525252525252525, 50, 4, 7);
        check("illegal_frame_err", 32'(fe_cnt - fe0), 32'h1);
        check("illegal_no_frame", 32'(fv_cnt - fv0), 32'h0);
        check("illegal_digits_held", bus.digits, 32'h8FEDCBA9);
        scan(64'h0D0D0D0D0D0D0D0D, 50, 0, 3);
        check("after_illegal_frame", 32'(fv_cnt - fv0), 32'h1);
        check("after_illegal_digits", bus.digits, 32'h22223333);
        scan(64'h9999999999999999, 40, 0, 7);
        check("clean_scan_frame", 32'(fv_cnt - fv0), 32'h2);
        check("clean_scan_digits", bus.digits, 32'h44444444);

        // Blank timeout with digits held, then a slot clears blank.
        fv0 = fv_cnt;
        drive(8'hFF, 8'hFF, 900);
        check("blank_before_timeout", {31'h0, bus.blank}, 32'h0);
        cycles(110);
        check("blank_after_timeout", {31'h0, bus.blank}, 32'h1);
        check("blank_digits_held", bus.digits, 32'h44444444);
        check("blank_no_frame", 32'(fv_cnt - fv0), 32'h0);
        drive(8'hFE, 8'h03, 3);
        check("slot_clears_blank", {31'h0, bus.blank}, 32'h0);

        // Asynchronous reset in the middle of a dwell.
        scan(64'h4949494949494949, 40, 0, 2);
        drive(8'hF7, 8'h49, 8);
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        #3 rst_n = 1'b0;
        #2;
        check_reset_outputs("mid_dwell_rst");
        cycles(3);
        rst_n = 1'b1;
        cycles(3);
        check("rst_no_frame_pulse", 32'(fv_cnt - fv0), 32'h0);
        check("rst_no_err_pulse", 32'(fe_cnt - fe0), 32'h0);
        check("rst_digits_stay_zero", bus.digits, 32'h0);
        scan(64'h4141414141414141, 30, 0, 7);
        drive(8'hFF, 8'hFF, 5);
        check("post_rst_frame", 32'(fv_cnt - fv0), 32'h1);
        check("post_rst_digits", bus.digits, 32'h66666666);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
